wavelet_sample_loader: RTL

WAVELET_SAMPLE_LOADER -- requirements
Module: wavelet_sample_loader

---
 rtl/wavelet_sample_loader.sv | 108 ++++++++++
 1 files changed

// File: rtl/wavelet_sample_loader.sv
// Captures pad samples on a synchronized strobe rising edge into a small circular FIFO
// feeding the wavelet core, with a sticky overflow flag and an accepted-sample counter.
module wavelet_sample_loader #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                     wb_clk_i,
    input  logic                     rst_n,
    input  logic                     active,
    input  logic [DATA_W-1:0]        ext_data,
    input  logic                     ext_strobe,
    input  logic                     clear_ovf,
    output logic [DATA_W-1:0]        sample_o,
    output logic                     sample_valid_o,
    input  logic                     sample_ready_i,
    output logic                     ovf_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic [15:0]              sample_cnt_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("DEPTH must be a power of 2 and at least 2");
    end

    // sync_reg[0..1] form the synchronizer, sync_reg[2] is the edge-detect history
    logic [2:0]        sync_reg;
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [LVL_W-1:0]  level_reg;
    logic              ovf_reg;
    logic [15:0]       sample_cnt_reg;
    logic [DATA_W-1:0] mem [DEPTH];

    logic push_req;
    logic push;
    logic pop;
    logic full;
    logic accept;
    logic overflow;

    assign push_req = sync_reg[1] & ~sync_reg[2];
    assign push     = push_req & active;
    assign full     = (level_reg == FULL_LVL);
    assign pop      = sample_valid_o & sample_ready_i;
    // A push into a full FIFO still fits when the head leaves in the same cycle
    assign accept   = push & (~full | pop);
    assign overflow = push & full & ~pop;

    assign sample_valid_o = active & (level_reg != '0);
    assign sample_o       = mem[rd_ptr_reg];
    assign level_o        = level_reg;
    assign ovf_o          = ovf_reg;
    assign sample_cnt_o   = sample_cnt_reg;

    always_ff @(posedge wb_clk_i) begin
        if (!rst_n) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[1:0], ext_strobe};
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (accept) begin
            mem[wr_ptr_reg] <= ext_data;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!rst_n) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            level_reg      <= '0;
            ovf_reg        <= 1'b0;
            sample_cnt_reg <= '0;
        end else if (!active) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
            if (clear_ovf) begin
                ovf_reg <= 1'b0;
            end
        end else begin
            if (accept) begin
                wr_ptr_reg     <= wr_ptr_reg + PTR_W'(1);
                sample_cnt_reg <= sample_cnt_reg + 16'd1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({accept, pop})
                2'b10:   level_reg <= level_reg + LVL_W'(1);
                2'b01:   level_reg <= level_reg - LVL_W'(1);
                default: level_reg <= level_reg;
            endcase
            if (overflow) begin
                ovf_reg <= 1'b1;
            end else if (clear_ovf) begin
                ovf_reg <= 1'b0;
            end
        end
    end

endmodule
